// File: rtl/debouncer_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | debouncer_edge: per-channel polarity, 2-flop sync, hysteresis debounce, pulses |
// | Revision: 1.0                                                                  |
// +--------------------------------------------------------------------------------+
module debouncer_edge #(
  parameter int               WIDTH              = 1,
  parameter int               SAMPLE_CNT_MAX     = 62500,
  parameter int               PULSE_CNT_MAX      = 200,
  parameter logic [WIDTH-1:0] ACTIVE_LOW         = {WIDTH{1'b0}},
  parameter int               WRAPPING_CNT_WIDTH = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1,
  parameter int               SAT_CNT_WIDTH      = $clog2(PULSE_CNT_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam logic [WRAPPING_CNT_WIDTH-1:0] C_TICK_LAST = WRAPPING_CNT_WIDTH'(SAMPLE_CNT_MAX - 1);
  localparam logic [SAT_CNT_WIDTH-1:0]      C_CNT_MAX   = SAT_CNT_WIDTH'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]              r_sync1;
  logic [WIDTH-1:0]              r_sync2;
  logic [WRAPPING_CNT_WIDTH-1:0] r_tick_cnt;
  logic                          w_tick;

  // Polarity is corrected ahead of the synchronizer so everything downstream is active-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= glitchy_signal ^ ACTIVE_LOW;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == C_TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + WRAPPING_CNT_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [SAT_CNT_WIDTH-1:0] r_cnt;
    logic [SAT_CNT_WIDTH-1:0] w_cnt_next;
    logic                     r_state;
    logic                     r_rise;
    logic                     r_fall;
    logic                     w_state_next;

    // State follows the integrator's next value so it flips on the same edge a bound is hit.
    always_comb begin
      w_cnt_next = r_cnt;
      if (w_tick) begin
        if (r_sync2[i]) begin
          if (r_cnt != C_CNT_MAX) begin
            w_cnt_next = r_cnt + SAT_CNT_WIDTH'(1);
          end
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - SAT_CNT_WIDTH'(1);
        end
      end
      w_state_next = r_state;
      if (w_cnt_next == C_CNT_MAX) begin
        w_state_next = 1'b1;
      end else if (w_cnt_next == '0) begin
        w_state_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_state <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_next;
        r_state <= w_state_next;
        r_rise  <= w_state_next & ~r_state;
        r_fall  <= ~w_state_next & r_state;
      end
    end

    assign debounced_signal[i] = r_state;
    assign rise_pulse[i]       = r_rise;
    assign fall_pulse[i]       = r_fall;
  end

endmodule
`default_nettype wire

// File: tb/tb_debouncer_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_debouncer_edge: scoreboard bench, two instances (4-cycle and 1-cycle) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_debouncer_edge;

  localparam int         P  = 3;
  localparam logic [3:0] AL = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] glitchy;
  logic [3:0] glitchy_fast;
  logic [3:0] deb, rise, fall;
  logic [3:0] deb_f, rise_f, fall_f;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  debouncer_edge #(
    .WIDTH(4), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(P), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .glitchy_signal(glitchy),
    .debounced_signal(deb), .rise_pulse(rise), .fall_pulse(fall)
  );

  debouncer_edge #(
    .WIDTH(4), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(P), .ACTIVE_LOW(AL)
  ) dut_fast (
    .clk(clk), .rst_n(rst_n), .glitchy_signal(glitchy_fast),
    .debounced_signal(deb_f), .rise_pulse(rise_f), .fall_pulse(fall_f)
  );

  // Reference model: edge number since reset, circular input history, integer integrators.
  logic [11:0] q_main[$];
  logic [11:0] q_fast[$];
  int          edge_n[2];
  int          cnt[2][4];
  logic [3:0]  st[2];
  logic [3:0]  xh[2][3];
  int          smax[2] = '{4, 1};

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b_%b_%b expected %b_%b_%b", name, $time,
               got[11:8], got[7:4], got[3:0], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      edge_n[k] = 0;
      st[k]     = 4'b0;
      for (int c = 0; c < 4; c++) cnt[k][c] = 0;
      for (int j = 0; j < 3; j++) xh[k][j] = 4'b0;
    end
    q_main.delete();
    q_fast.delete();
    q_main.push_back(12'b0);
    q_fast.push_back(12'b0);
  endtask

  task automatic model_step();
    logic [3:0] x, s, prev, rv, fv;
    for (int k = 0; k < 2; k++) begin
      x = ((k == 0) ? glitchy : glitchy_fast) ^ AL;
      edge_n[k]++;
      s = (edge_n[k] >= 3) ? xh[k][(edge_n[k] - 2) % 3] : 4'b0;
      xh[k][edge_n[k] % 3] = x;
      prev = st[k];
      for (int c = 0; c < 4; c++) begin
        if (edge_n[k] % smax[k] == 0) begin
          if (s[c]) cnt[k][c] = (cnt[k][c] < P) ? cnt[k][c] + 1 : P;
          else      cnt[k][c] = (cnt[k][c] > 0) ? cnt[k][c] - 1 : 0;
        end
        if (cnt[k][c] == P)      st[k][c] = 1'b1;
        else if (cnt[k][c] == 0) st[k][c] = 1'b0;
      end
      rv = st[k] & ~prev;
      fv = ~st[k] & prev;
      if (k == 0) q_main.push_back({st[k], rv, fv});
      else        q_fast.push_back({st[k], rv, fv});
    end
  endtask

  initial begin
    logic seen;
    bit   found;
    int   hold;

    rst_n        = 1'b0;
    glitchy      = 4'b0101;
    glitchy_fast = 4'b0101;

    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
      end
      forever begin
        @(negedge clk);
        if (q_main.size() > 0) check("sb_main", {deb, rise, fall}, q_main.pop_front());
        if (q_fast.size() > 0) check("sb_fast", {deb_f, rise_f, fall_f}, q_fast.pop_front());
      end
    join_none

    // Reset held with inputs active
    repeat (5) @(negedge clk);
    check("reset_hold_main", {deb, rise, fall}, 12'b0);
    check("reset_hold_fast", {deb_f, rise_f, fall_f}, 12'b0);

    // Press ch0 and active-low ch3 from edge 1
    glitchy      = 4'b0001;
    glitchy_fast = 4'b0001;
    rst_n        = 1'b1;
    repeat (4) @(negedge clk);
    check("fast_edge4", {deb_f, rise_f, fall_f}, 12'b0);
    @(negedge clk);
    check("fast_edge5", {deb_f, rise_f, fall_f}, {4'b1001, 4'b1001, 4'b0000});
    repeat (6) @(negedge clk);
    check("press_edge11", {deb, rise, fall}, 12'b0);
    @(negedge clk);
    check("press_edge12", {deb, rise, fall}, {4'b1001, 4'b1001, 4'b0000});
    @(negedge clk);
    check("press_edge13", {deb, rise, fall}, {4'b1001, 4'b0000, 4'b0000});

    // Release ch0: hysteresis holds through two low ticks
    glitchy      = 4'b0000;
    glitchy_fast = 4'b0000;
    repeat (10) @(negedge clk);
    check("release_edge23", {deb, rise, fall}, {4'b1001, 4'b0000, 4'b0000});
    @(negedge clk);
    check("release_edge24", {deb, rise, fall}, {4'b1000, 4'b0000, 4'b0001});
    @(negedge clk);
    check("release_edge25", {deb, rise, fall}, {4'b1000, 4'b0000, 4'b0000});

    // Glitch rejection on ch1
    seen = 1'b0;
    for (int r = 0; r < 10; r++) begin
      glitchy[1] = 1'b1;
      repeat (4) begin @(negedge clk); seen |= deb[1] | rise[1] | fall[1]; end
      glitchy[1] = 1'b0;
      repeat (4) begin @(negedge clk); seen |= deb[1] | rise[1] | fall[1]; end
    end
    check("glitch_ch1", {11'b0, seen}, 12'b0);

    // Simultaneous ch0+ch2, and fast instance 2+3 cycle latency
    glitchy      = 4'b0101;
    glitchy_fast = 4'b0100;
    repeat (4) @(negedge clk);
    check("fast_lat4", {deb_f, rise_f, fall_f}, {4'b1000, 4'b0000, 4'b0000});
    @(negedge clk);
    check("fast_lat5", {deb_f, rise_f, fall_f}, {4'b1100, 4'b0100, 4'b0000});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rise != 4'b0) found = 1'b1;
    end
    check("simul_rise", {deb, rise, fall}, {4'b1101, 4'b0101, 4'b0000});

    // Randomized traffic
    for (int r = 0; r < 80; r++) begin
      glitchy      = 4'($urandom);
      glitchy_fast = 4'($urandom);
      hold         = $urandom_range(1, 30);
      repeat (hold) @(negedge clk);
    end

    // Asynchronous reset while ch0 is set
    glitchy      = 4'b0001;
    glitchy_fast = 4'b0001;
    repeat (24) @(negedge clk);
    check("pre_reset_set", {11'b0, deb[0]}, 12'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {deb, rise, fall}, 12'b0);
    check("async_reset_fast", {deb_f, rise_f, fall_f}, 12'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
